// File: rtl/player_pkg.sv
// Shared types and defaults for the music player sequencer.
package player_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } state_e;

  localparam int NUM_TRACKS_DEF     = 4;
  localparam int ADDR_W_DEF         = 12;
  localparam int VOL_BITS_DEF       = 4;
  localparam int VOL_DEFAULT_DEF    = 8;
  localparam int RESTART_THRESH_DEF = 256;
  localparam int LOOP_ALL_DEF       = 0;

  function automatic int trk_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter clamped at 0 and all-ones.
module sat_counter #(
  parameter int W       = 4,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && cnt_q != '1)
      cnt_d = cnt_q + W'(1);
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= W'(RST_VAL);
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/playback_controller.sv
// Transport sequencer: play/pause/skip FSM, track and sample address,
// volume level.
module playback_controller
  import player_pkg::*;
#(
  parameter int NUM_TRACKS     = NUM_TRACKS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int VOL_BITS       = VOL_BITS_DEF,
  parameter int VOL_DEFAULT    = VOL_DEFAULT_DEF,
  parameter int RESTART_THRESH = RESTART_THRESH_DEF,
  parameter int LOOP_ALL       = LOOP_ALL_DEF,
  localparam int TRK_W         = trk_w(NUM_TRACKS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                play_pause,
  input  logic                volume_up,
  input  logic                volume_down,
  input  logic                forward,
  input  logic                backward,
  input  logic                sample_tick,
  input  logic                track_end,
  output logic [TRK_W-1:0]    track_sel,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic [VOL_BITS-1:0] volume,
  output logic                playing,
  output logic                paused,
  output logic                track_change
);

  localparam logic [TRK_W-1:0]  LAST   = TRK_W'(NUM_TRACKS - 1);
  localparam logic [ADDR_W-1:0] THRESH = ADDR_W'(RESTART_THRESH);

  state_e            state_q, state_d;
  logic [TRK_W-1:0]  trk_q, trk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tc_q, tc_d;
  logic              play_q, pause_q;

  always_comb begin
    state_d = state_q;
    trk_d   = trk_q;
    addr_d  = addr_q;
    tc_d    = 1'b0;
    if (play_pause) begin
      unique case (state_q)
        STOPPED: begin
          state_d = PLAYING;
          addr_d  = '0;
        end
        PLAYING: state_d = PAUSED;
        default: state_d = PLAYING;
      endcase
    end else if (forward || backward) begin
      addr_d = '0;
      tc_d   = 1'b1;
      if (state_q == PAUSED) state_d = STOPPED;
      if (forward)
        trk_d = (trk_q == LAST) ? '0 : trk_q + TRK_W'(1);
      else if (!(state_q == PLAYING && addr_q >= THRESH))
        trk_d = (trk_q == '0) ? LAST : trk_q - TRK_W'(1);
    end else if (sample_tick && state_q == PLAYING) begin
      if (!track_end && addr_q != '1) begin
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        // End of track: advance, wrap, or stop after the last one
        addr_d = '0;
        tc_d   = 1'b1;
        if (trk_q != LAST) begin
          trk_d = trk_q + TRK_W'(1);
        end else begin
          trk_d = '0;
          if (LOOP_ALL == 0) state_d = STOPPED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      trk_q   <= '0;
      addr_q  <= '0;
      tc_q    <= 1'b0;
      play_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trk_q   <= trk_d;
      addr_q  <= addr_d;
      tc_q    <= tc_d;
      play_q  <= (state_d == PLAYING);
      pause_q <= (state_d == PAUSED);
    end
  end

  sat_counter #(
    .W       (VOL_BITS),
    .RST_VAL (VOL_DEFAULT)
  ) u_vol (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (volume_up),
    .dec_i (volume_down),
    .cnt_o (volume)
  );

  assign track_sel    = trk_q;
  assign rom_addr     = addr_q;
  assign playing      = play_q;
  assign paused       = pause_q;
  assign track_change = tc_q;

endmodule

// File: tb/tb_playback_controller.sv
// Bench: two controllers (stop-at-end and loop-all) against a
// behavioural model; directed steps then random commands.
module tb_playback_controller;

  localparam int M_STOP  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic play_pause = 0, volume_up = 0, volume_down = 0;
  logic forward = 0, backward = 0, sample_tick = 0, track_end = 0;

  logic [1:0]  ts0, ts1;
  logic [11:0] ra0, ra1;
  logic [3:0]  vol0, vol1;
  logic        pl0, pl1, pa0, pa1, tc0, tc1;

  int checks = 0;
  int failures = 0;

  int mst[2], mtrk[2], maddr[2], mvol[2], mtc[2];

  always #5 clk = ~clk;

  playback_controller #(.LOOP_ALL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .play_pause(play_pause),
    .volume_up(volume_up), .volume_down(volume_down),
    .forward(forward), .backward(backward),
    .sample_tick(sample_tick), .track_end(track_end),
    .track_sel(ts0), .rom_addr(ra0), .volume(vol0),
    .playing(pl0), .paused(pa0), .track_change(tc0)
  );

  playback_controller #(.LOOP_ALL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .play_pause(play_pause),
    .volume_up(volume_up), .volume_down(volume_down),
    .forward(forward), .backward(backward),
    .sample_tick(sample_tick), .track_end(track_end),
    .track_sel(ts1), .rom_addr(ra1), .volume(vol1),
    .playing(pl1), .paused(pa1), .track_change(tc1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      mst[l] = M_STOP; mtrk[l] = 0; maddr[l] = 0;
      mvol[l] = 8; mtc[l] = 0;
    end
  endtask

  task automatic model_step(input bit pp, vu, vd, fw, bw, tk, te);
    for (int l = 0; l < 2; l++) begin
      if (vu && !vd && mvol[l] < 15) mvol[l]++;
      if (vd && !vu && mvol[l] > 0) mvol[l]--;
      mtc[l] = 0;
      if (pp) begin
        if (mst[l] == M_STOP) begin
          mst[l] = M_PLAY; maddr[l] = 0;
        end else if (mst[l] == M_PLAY) mst[l] = M_PAUSE;
        else mst[l] = M_PLAY;
      end else if (fw || bw) begin
        if (fw) mtrk[l] = (mtrk[l] + 1) % 4;
        else if (!(mst[l] == M_PLAY && maddr[l] >= 256))
          mtrk[l] = (mtrk[l] + 3) % 4;
        maddr[l] = 0; mtc[l] = 1;
        if (mst[l] == M_PAUSE) mst[l] = M_STOP;
      end else if (tk && mst[l] == M_PLAY) begin
        if (!te && maddr[l] != 4095) maddr[l]++;
        else begin
          maddr[l] = 0; mtc[l] = 1;
          if (mtrk[l] < 3) mtrk[l]++;
          else begin
            mtrk[l] = 0;
            if (l == 0) mst[l] = M_STOP;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("trk0", ts0, mtrk[0]);  chk("trk1", ts1, mtrk[1]);
    chk("addr0", ra0, maddr[0]); chk("addr1", ra1, maddr[1]);
    chk("vol0", vol0, mvol[0]);  chk("vol1", vol1, mvol[1]);
    chk("play0", pl0, mst[0] == M_PLAY);
    chk("play1", pl1, mst[1] == M_PLAY);
    chk("pause0", pa0, mst[0] == M_PAUSE);
    chk("pause1", pa1, mst[1] == M_PAUSE);
    chk("tc0", tc0, mtc[0]);     chk("tc1", tc1, mtc[1]);
  endtask

  task automatic step(input bit pp, vu, vd, fw, bw, tk, te);
    play_pause = pp; volume_up = vu; volume_down = vd;
    forward = fw; backward = bw; sample_tick = tk; track_end = te;
    @(posedge clk);
    model_step(pp, vu, vd, fw, bw, tk, te);
    #1;
    play_pause = 0; volume_up = 0; volume_down = 0;
    forward = 0; backward = 0; sample_tick = 0; track_end = 0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all();

    step(1, 0, 0, 0, 0, 0, 0);
    chk("play_start", pl0, 1);
    ticks(5);
    chk("addr_5", ra0, 5);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("paused", pa0, 1);
    ticks(3);
    chk("addr_hold", ra0, 5);

    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);
    chk("stop_trk0", ts0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("bwd_wrap", ts0, 3);
    chk("bwd_tc", tc0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("tc_drop", tc0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
    chk("fwd_wrap", ts0, 0);

    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0);
    chk("vol_max", vol0, 15);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0, 0);
    chk("vol_min", vol0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    chk("vol_both", vol0, 7);

    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    ticks(300);
    chk("addr_300", ra0, 300);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("restart_trk", ts0, 1);
    chk("restart_addr", ra0, 0);
    ticks(10);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("prev_trk", ts0, 0);

    step(0, 0, 0, 0, 1, 0, 0);
    ticks(3);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("end_stop", pl0, 0);
    chk("end_stop_trk", ts0, 0);
    chk("end_loop", pl1, 1);
    chk("end_loop_trk", ts1, 0);

    reset_mid();
    step(1, 0, 0, 0, 0, 0, 0);
    ticks(40);
    step(1, 0, 0, 1, 0, 1, 0);
    chk("prio_pause", pa0, 1);
    chk("prio_trk", ts0, 0);
    chk("prio_addr", ra0, 40);

    step(1, 0, 0, 0, 0, 0, 0);
    ticks(4055);
    chk("addr_max", ra0, 4095);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ones_trk", ts0, 1);
    chk("ones_tc", tc0, 1);

    ticks(20);
    reset_mid();

    for (int i = 0; i < 2000; i++)
      step($urandom_range(7) == 0, $urandom_range(3) == 0,
           $urandom_range(3) == 0, $urandom_range(9) == 0,
           $urandom_range(9) == 0, $urandom_range(1) == 0,
           $urandom_range(15) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
